// File: rtl/bp_be_stride_detector_pkg.sv
// Shared types and helpers for the stride detector slice.
// Entry struct and width come from declare/width macros so each instance can
// size the struct from its own parameters.
`ifndef BP_BE_STRIDE_DETECTOR_PKG_MACROS
`define BP_BE_STRIDE_DETECTOR_PKG_MACROS

`define BP_BE_STRIDE_ENTRY_WIDTH(tag_w, addr_w, stride_w, conf_w, loop_w) \
  (1 + (tag_w) + (addr_w) + (stride_w) + (conf_w) + (loop_w))

// valid is the MSB so the table can clear it without knowing the layout.
`define BP_BE_STRIDE_ENTRY_DECLARE(tag_w, addr_w, stride_w, conf_w, loop_w) \
  typedef struct packed { \
    logic                  valid; \
    logic [(tag_w)-1:0]    tag; \
    logic [(addr_w)-1:0]   last_addr; \
    logic [(stride_w)-1:0] stride; \
    logic [(conf_w)-1:0]   conf; \
    logic [(loop_w)-1:0]   issued; \
  } bp_be_stride_entry_s

`endif

package bp_be_stride_detector_pkg;

  localparam int unsigned dpath_width_gp = 64;
  localparam int unsigned vaddr_width_gp = 39;

  // Nonzero and representable as an unsigned stride; negative deltas wrap
  // to huge values and land out of range.
  function automatic logic stride_in_range(input logic [dpath_width_gp-1:0] delta,
                                           input int unsigned stride_width);
    return (delta != '0) &&
           ((stride_width >= dpath_width_gp) || ((delta >> stride_width) == '0));
  endfunction

endpackage

// File: rtl/bp_be_stride_table.sv
// Direct-mapped flop table: one combinational read port, one write port.
// Flush clears every valid bit (entry MSB).
module bp_be_stride_table
  import bp_be_stride_detector_pkg::*;
#(
  parameter int unsigned entries_p = 8,
  parameter int unsigned width_p   = 8,
  localparam int unsigned IdxWidth = $clog2(entries_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                flush_i,
  input  logic [IdxWidth-1:0] r_idx_i,
  output logic [width_p-1:0]  r_data_o,
  input  logic                w_v_i,
  input  logic [IdxWidth-1:0] w_idx_i,
  input  logic [width_p-1:0]  w_data_i
);

  logic [width_p-1:0] mem_q [entries_p];

  assign r_data_o = mem_q[r_idx_i];

  // Storage update: reset wipes, flush invalidates, else single write.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < entries_p; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < entries_p; i++) mem_q[i][width_p-1] <= 1'b0;
    end else if (w_v_i) begin
      mem_q[w_idx_i] <= w_data_i;
    end
  end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Per-PC constant-stride detector feeding the BE prefetch generator.
// Optional BP_BE_STRIDE_DETECTOR_STATS_EN adds trigger/drop counters.
module bp_be_stride_detector
  import bp_be_stride_detector_pkg::*;
#(
  parameter int unsigned vaddr_width_p    = vaddr_width_gp,
  parameter int unsigned entries_p        = 8,
  parameter int unsigned loop_range_p     = 8,
  parameter int unsigned stride_width_p   = 8,
  parameter int unsigned conf_width_p     = 2,
  parameter int unsigned threshold_p      = 2,
  parameter int unsigned prefetch_depth_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic                      v_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [dpath_width_gp-1:0] eff_addr_i,
  output logic                      v_o,
  input  logic                      ready_and_i,
  output logic [vaddr_width_p-1:0]  pc_o,
  output logic [dpath_width_gp-1:0] eff_addr_o,
  output logic [stride_width_p-1:0] stride_o,
  output logic [loop_range_p-1:0]   loop_counter_o
`ifdef BP_BE_STRIDE_DETECTOR_STATS_EN
  , output logic [31:0]             trigger_cnt_o
  , output logic [31:0]             drop_cnt_o
`endif
);

  localparam int unsigned IdxWidth = $clog2(entries_p);
  localparam int unsigned TagWidth = vaddr_width_p - 1 - IdxWidth;
  localparam int unsigned EntryWidth = `BP_BE_STRIDE_ENTRY_WIDTH(TagWidth, dpath_width_gp,
      stride_width_p, conf_width_p, loop_range_p);

  `BP_BE_STRIDE_ENTRY_DECLARE(TagWidth, dpath_width_gp, stride_width_p, conf_width_p,
      loop_range_p);

  localparam logic [conf_width_p-1:0] ConfMax  = '1;
  localparam logic [conf_width_p-1:0] ConfThr  = conf_width_p'(threshold_p);
  localparam logic [conf_width_p-1:0] ConfPre  = conf_width_p'(threshold_p - 1);
  localparam logic [loop_range_p-1:0] IssueEnd = loop_range_p'(prefetch_depth_p - 1);

  logic [IdxWidth-1:0]       idx;
  logic [TagWidth-1:0]       tag;
  logic                      unused_pc;
  bp_be_stride_entry_s       rd_entry, wr_entry;
  logic                      hit, match, trigger, trigger_v, accept, drop;
  logic [dpath_width_gp-1:0] delta;

  logic                      v_q, v_d;
  logic [vaddr_width_p-1:0]  pc_q, pc_d;
  logic [dpath_width_gp-1:0] eff_addr_q, eff_addr_d;
  logic [stride_width_p-1:0] stride_q, stride_d;

  // Bit 0 of the PC never distinguishes loads.
  assign idx       = pc_i[1 +: IdxWidth];
  assign tag       = pc_i[vaddr_width_p-1:1+IdxWidth];
  assign unused_pc = pc_i[0];

  bp_be_stride_table #(
    .entries_p (entries_p),
    .width_p   (EntryWidth)
  ) u_table (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (flush_i),
    .r_idx_i   (idx),
    .r_data_o  (rd_entry),
    .w_v_i     (v_i & ~flush_i),
    .w_idx_i   (idx),
    .w_data_i  (wr_entry)
  );

  assign hit   = rd_entry.valid && (rd_entry.tag == tag);
  assign delta = eff_addr_i - rd_entry.last_addr;
  assign match = stride_in_range(delta, stride_width_p) &&
                 (delta[stride_width_p-1:0] == rd_entry.stride);

  // Entry update and trigger decision for the observed load.
  always_comb begin
    wr_entry = rd_entry;
    trigger  = 1'b0;
    if (!hit) begin
      wr_entry           = '0;
      wr_entry.valid     = 1'b1;
      wr_entry.tag       = tag;
      wr_entry.last_addr = eff_addr_i;
    end else begin
      wr_entry.last_addr = eff_addr_i;
      if (match) begin
        if (rd_entry.conf != ConfMax) wr_entry.conf = rd_entry.conf + conf_width_p'(1);
        if (rd_entry.conf == ConfPre) begin
          trigger         = 1'b1;
          wr_entry.issued = '0;
        end else if (rd_entry.conf >= ConfThr) begin
          // Re-issue every prefetch_depth_p matching loads.
          if (rd_entry.issued == IssueEnd) begin
            trigger         = 1'b1;
            wr_entry.issued = '0;
          end else begin
            wr_entry.issued = rd_entry.issued + loop_range_p'(1);
          end
        end
      end else begin
        wr_entry.stride = delta[stride_width_p-1:0];
        wr_entry.conf   = '0;
        wr_entry.issued = '0;
      end
    end
  end

  assign trigger_v = v_i && !flush_i && trigger;
  assign accept    = trigger_v && (!v_q || ready_and_i);
  assign drop      = trigger_v && v_q && !ready_and_i;

  // Output register next state: load on accept, clear on consume.
  always_comb begin
    v_d        = v_q;
    pc_d       = pc_q;
    eff_addr_d = eff_addr_q;
    stride_d   = stride_q;
    if (accept) begin
      v_d        = 1'b1;
      pc_d       = pc_i;
      eff_addr_d = eff_addr_i;
      stride_d   = rd_entry.stride;
    end else if (v_q && ready_and_i) begin
      v_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q        <= 1'b0;
      pc_q       <= '0;
      eff_addr_q <= '0;
      stride_q   <= '0;
    end else begin
      v_q        <= v_d;
      pc_q       <= pc_d;
      eff_addr_q <= eff_addr_d;
      stride_q   <= stride_d;
    end
  end

  assign v_o            = v_q;
  assign pc_o           = pc_q;
  assign eff_addr_o     = eff_addr_q;
  assign stride_o       = stride_q;
  assign loop_counter_o = loop_range_p'(prefetch_depth_p);

`ifdef BP_BE_STRIDE_DETECTOR_STATS_EN
  logic [31:0] trigger_cnt_q, drop_cnt_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      trigger_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (accept) trigger_cnt_q <= trigger_cnt_q + 32'd1;
      if (drop)   drop_cnt_q    <= drop_cnt_q + 32'd1;
    end
  end

  assign trigger_cnt_o = trigger_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
`endif

endmodule
